// File: rtl/forward_batch_sequencer.sv
// forward_batch_sequencer
// Runs one batch of training samples through the forward datapath. It issues
// sample-memory reads and pulses the datapath input-register load. A
// LATENCY-deep valid pipeline tracks the samples in flight and drives the
// output-register capture and the cost-accumulator clear/enable.
// Optional feature: define SEQ_STALL_CNT_EN to add stall_cycles. This output
// counts the ISSUE cycles spent waiting on mem_ready and saturates at 16'hFFFF.
module forward_batch_sequencer #(
   parameter int ADDR_W  = 8,
   parameter int LATENCY = 4,
   parameter int CNT_W   = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [ADDR_W-1:0] batch_len,
   input  logic              mem_ready,
   output logic              sample_rd,
   output logic [ADDR_W-1:0] sample_addr,
   output logic              in_load,
   output logic              out_capture,
   output logic              acc_clear,
   output logic              acc_en,
   output logic              busy,
   output logic              done,
   output logic [CNT_W-1:0]  samples_done
`ifdef SEQ_STALL_CNT_EN
   ,
   output logic [15:0]       stall_cycles
`endif
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_CLEAR = 3'd1;
   localparam logic [2:0] S_ISSUE = 3'd2;
   localparam logic [2:0] S_DRAIN = 3'd3;
   localparam logic [2:0] S_DONE  = 3'd4;

   // Every valid-pipeline stage except the capture stage. A sample sitting in
   // one of these stages still has a capture ahead of it.
   localparam logic [LATENCY-1:0] LOW_MASK = LATENCY'((64'd1 << (LATENCY-1)) - 64'd1);

   logic [2:0]         state_q, state_d;
   logic [ADDR_W-1:0]  base_q;
   logic [ADDR_W-1:0]  len_q;
   logic [ADDR_W-1:0]  idx_q;
   logic               load_q;
   logic [LATENCY-1:0] vld_q;
   logic [CNT_W-1:0]   cnt_q;
   logic               start_acc;
   logic               rd;
   logic               last_rd;
   logic               pending;

   assign start_acc = (state_q == S_IDLE) && start;
   assign rd        = (state_q == S_ISSUE) && mem_ready;
   assign last_rd   = rd && (idx_q == (len_q - ADDR_W'(1)));
   // Samples still in flight after this cycle's capture (if any) has happened.
   assign pending   = load_q || (|(vld_q & LOW_MASK));

   assign sample_rd    = rd;
   assign sample_addr  = base_q + idx_q;
   assign in_load      = load_q;
   assign out_capture  = vld_q[LATENCY-1];
   assign acc_en       = vld_q[LATENCY-1];
   assign acc_clear    = (state_q == S_CLEAR);
   assign busy         = (state_q != S_IDLE);
   assign done         = (state_q == S_DONE);
   assign samples_done = cnt_q;

   // Next-state selection for the batch sequencing FSM
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (start) state_d = (batch_len == '0) ? S_DONE : S_CLEAR;
         S_CLEAR: state_d = S_ISSUE;
         S_ISSUE: if (last_rd) state_d = S_DRAIN;
         S_DRAIN: if (!pending) state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // State, batch parameters, issue index, valid pipeline and capture count
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= S_IDLE;
         base_q  <= '0;
         len_q   <= '0;
         idx_q   <= '0;
         load_q  <= 1'b0;
         vld_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         load_q  <= rd;
         vld_q   <= (vld_q << 1) | LATENCY'(load_q);
         if (start_acc) begin
            base_q <= base_addr;
            len_q  <= batch_len;
            idx_q  <= '0;
            cnt_q  <= '0;
         end else begin
            if (rd) idx_q <= idx_q + ADDR_W'(1);
            if (vld_q[LATENCY-1]) cnt_q <= cnt_q + CNT_W'(1);
         end
      end
   end

`ifdef SEQ_STALL_CNT_EN
   logic [15:0] stall_q;

   assign stall_cycles = stall_q;

   // Saturating count of ISSUE cycles lost to a busy sample memory
   always_ff @(posedge clk) begin
      if (!reset) begin
         stall_q <= '0;
      end else if (start_acc) begin
         stall_q <= '0;
      end else if ((state_q == S_ISSUE) && !mem_ready && (stall_q != 16'hFFFF)) begin
         stall_q <= stall_q + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_forward_batch_sequencer.sv
// Scoreboard bench for forward_batch_sequencer (LATENCY=4, ADDR_W=8, CNT_W=8).
// Expected read/load/capture/clear/done events are queued when a batch is
// launched and popped as the design produces them.
module tb_forward_batch_sequencer;
   localparam int AW  = 8;
   localparam int LAT = 4;
   localparam int CW  = 8;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          start = 1'b0;
   logic          mem_ready = 1'b0;
   logic [AW-1:0] base_addr = '0;
   logic [AW-1:0] batch_len = '0;
   logic          sample_rd, in_load, out_capture, acc_clear, acc_en, busy, done;
   logic [AW-1:0] sample_addr;
   logic [CW-1:0] samples_done;
`ifdef SEQ_STALL_CNT_EN
   logic [15:0]   stall_cycles;
`endif

   int errs = 0;
   int checks = 0;
   int cyc = 0;
   int exp_rd_cyc[$];
   logic [AW-1:0] exp_rd_addr[$];
   int exp_ld[$];
   int exp_cap[$];
   int exp_clr[$];
   int exp_done[$];
   bit mon_on = 1'b0;
   int busy_lo = 0;
   int busy_hi = -1;

   forward_batch_sequencer #(.ADDR_W(AW), .LATENCY(LAT), .CNT_W(CW)) dut (
      .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
      .batch_len(batch_len), .mem_ready(mem_ready), .sample_rd(sample_rd),
      .sample_addr(sample_addr), .in_load(in_load), .out_capture(out_capture),
      .acc_clear(acc_clear), .acc_en(acc_en), .busy(busy), .done(done),
      .samples_done(samples_done)
`ifdef SEQ_STALL_CNT_EN
      , .stall_cycles(stall_cycles)
`endif
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
      end
   endtask

   // Event monitor: sampled on the falling edge, away from the active edge
   always @(negedge clk) begin
      if (mon_on) begin
         if (sample_rd) begin
            if (exp_rd_cyc.size() == 0) chk_eq("rd_extra", 32'(sample_rd), 32'd0);
            else begin
               chk_eq("rd_cyc", 32'(cyc), 32'(exp_rd_cyc.pop_front()));
               chk_eq("rd_addr", 32'(sample_addr), 32'(exp_rd_addr.pop_front()));
            end
         end
         if (in_load) begin
            if (exp_ld.size() == 0) chk_eq("ld_extra", 32'(in_load), 32'd0);
            else chk_eq("ld_cyc", 32'(cyc), 32'(exp_ld.pop_front()));
         end
         if (out_capture || acc_en) begin
            if (exp_cap.size() == 0) chk_eq("cap_extra", 32'({out_capture, acc_en}), 32'd0);
            else begin
               chk_eq("cap_cyc", 32'(cyc), 32'(exp_cap.pop_front()));
               chk_eq("cap_pair", 32'({out_capture, acc_en}), 32'd3);
            end
         end
         if (acc_clear) begin
            if (exp_clr.size() == 0) chk_eq("clr_extra", 32'(acc_clear), 32'd0);
            else chk_eq("clr_cyc", 32'(cyc), 32'(exp_clr.pop_front()));
         end
         if (done) begin
            if (exp_done.size() == 0) chk_eq("done_extra", 32'(done), 32'd0);
            else chk_eq("done_cyc", 32'(cyc), 32'(exp_done.pop_front()));
         end
         chk_eq("busy", 32'(busy), 32'((cyc >= busy_lo) && (cyc <= busy_hi)));
      end
   end

   task automatic chk_drained();
      chk_eq("rd_left", 32'(exp_rd_cyc.size()), 32'd0);
      chk_eq("ld_left", 32'(exp_ld.size()), 32'd0);
      chk_eq("cap_left", 32'(exp_cap.size()), 32'd0);
      chk_eq("clr_left", 32'(exp_clr.size()), 32'd0);
      chk_eq("done_left", 32'(exp_done.size()), 32'd0);
      exp_rd_cyc.delete(); exp_rd_addr.delete(); exp_ld.delete();
      exp_cap.delete(); exp_clr.delete(); exp_done.delete();
   endtask

   // Launch one batch at the current cycle; stall_m bit k drops mem_ready in
   // relative cycle k; spike>0 re-pulses start with junk parameters then.
   task automatic run_batch(input logic [AW-1:0] b, input logic [AW-1:0] n,
                            input logic [63:0] stall_m, input int spike);
      int t0, c, idx, last_cap, stalls, done_c;
      t0 = cyc; c = t0 + 2; idx = 0; stalls = 0; last_cap = t0;
      if (n != 0) exp_clr.push_back(t0 + 1);
      while (idx < int'(n)) begin
         if (((c - t0) < 64) && stall_m[c - t0]) stalls++;
         else begin
            exp_rd_cyc.push_back(c);
            exp_rd_addr.push_back(b + AW'(idx));
            exp_ld.push_back(c + 1);
            exp_cap.push_back(c + 1 + LAT);
            last_cap = c + 1 + LAT;
            idx++;
         end
         c++;
      end
      done_c = (n == 0) ? t0 + 1 : last_cap + 1;
      exp_done.push_back(done_c);
      busy_lo = t0 + 1; busy_hi = done_c;
      base_addr = b; batch_len = n; start = 1'b1; mem_ready = !stall_m[0];
      for (int k = 1; k <= done_c - t0 + 2; k++) begin
         @(posedge clk); #1;
         start = (k == spike);
         if (k == spike) begin
            base_addr = ~b;
            batch_len = n + AW'(3);
         end
         mem_ready = (k < 64) ? !stall_m[k] : 1'b1;
      end
      start = 1'b0;
      chk_eq("samples_done", 32'(samples_done), 32'(n));
      chk_eq("idle_busy", 32'(busy), 32'd0);
`ifdef SEQ_STALL_CNT_EN
      chk_eq("stall_cycles", 32'(stall_cycles), 32'(stalls));
`endif
      chk_drained();
   endtask

   // len=5 batch, reset pulsed for one cycle right after the second capture
   task automatic run_reset_abort();
      int t0;
      logic [AW-1:0] b;
      t0 = cyc; b = 8'h40;
      exp_clr.push_back(t0 + 1);
      for (int i = 0; i < 5; i++) begin
         exp_rd_cyc.push_back(t0 + 2 + i);
         exp_rd_addr.push_back(b + AW'(i));
         exp_ld.push_back(t0 + 3 + i);
      end
      exp_cap.push_back(t0 + 7);
      exp_cap.push_back(t0 + 8);
      busy_lo = t0 + 1; busy_hi = t0 + 8;
      base_addr = b; batch_len = 8'd5; start = 1'b1; mem_ready = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         @(posedge clk); #1;
         start = 1'b0;
         if (k == 8) reset = 1'b0;
      end
      @(posedge clk); #1;
      reset = 1'b1;
      chk_eq("rst_busy", 32'(busy), 32'd0);
      chk_eq("rst_done", 32'(done), 32'd0);
      chk_eq("rst_strobes", 32'({sample_rd, in_load, out_capture, acc_clear, acc_en}), 32'd0);
      chk_eq("rst_samples_done", 32'(samples_done), 32'd0);
      repeat (12) begin
         @(posedge clk); #1;
      end
      chk_drained();
   endtask

   initial begin
      reset = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk_eq("reset_busy", 32'(busy), 32'd0);
      chk_eq("reset_done", 32'(done), 32'd0);
      chk_eq("reset_strobes", 32'({sample_rd, in_load, out_capture, acc_clear, acc_en}), 32'd0);
      chk_eq("reset_samples_done", 32'(samples_done), 32'd0);
`ifdef SEQ_STALL_CNT_EN
      chk_eq("reset_stall", 32'(stall_cycles), 32'd0);
`endif
      reset = 1'b1;
      mon_on = 1'b1;
      repeat (2) begin
         @(posedge clk); #1;
      end
      run_batch(8'h10, 8'd3, 64'h0, -1);
      run_batch(8'h10, 8'd3, 64'h18, -1);
      run_batch(8'hFE, 8'd3, 64'h0, -1);
      run_batch(8'h20, 8'd0, 64'h0, -1);
      run_batch(8'h30, 8'd4, 64'h0, 3);
      for (int r = 0; r < 3; r++)
         run_batch(AW'($urandom), AW'($urandom_range(1, 7)), {32'($urandom), 32'($urandom)}, -1);
      run_reset_abort();
      run_batch(8'h55, 8'd2, 64'h4, -1);
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
